wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 20 ++
 rtl/wb_regfile_core.sv | 44 ++++
 rtl/wb_regfile.sv | 92 +++++++++
 tb/tb_wb_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
//   Shared definitions for the writeback register file:
//   - default data/address widths
//   - bit positions of the writeback control field (mem-select, regwrite)
//   - index of the hard-wired zero register
//   Optional build macro used by the design: WB_BYPASS_EN (write-through reads).
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Writeback control field layout: {mem_sel, regwrite}
  localparam int WB_CTRL_MEM_SEL_BIT  = 1;
  localparam int WB_CTRL_REGWRITE_BIT = 0;
  localparam int WB_CTRL_W            = 2;

  // Register 0 is hard-wired to zero.
  localparam int R0_IDX = 0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_core.sv
// regfile_core
//   Register storage: 2**ADDR_W words of DATA_W bits, two asynchronous read
//   ports and one synchronous write port. Synchronous active-high reset clears
//   every word. Write qualification (including the R0 guard) is the caller's job.
// Ports:
//   clk, rst            clock and synchronous reset
//   we, waddr, wdata    write port, applied on posedge clk
//   raddr_a, rdata_a    read port A (combinational)
//   raddr_b, rdata_b    read port B (combinational)
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// wb_regfile
//   Writeback stage plus register file. Selects the writeback value (memory
//   load or ALU result), commits it to the destination register, counts
//   committed writes and pulses wb_fire the cycle after each commit.
//   Register 0 always reads zero and is never written.
// Build macro: WB_BYPASS_EN -- when defined, a read of the register being
//   committed this cycle returns wb_data directly (write-through); otherwise
//   the stored value is returned and the new value appears after the edge.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_valid                  writeback slot holds a live instruction
//   mux3                      source select: 1 = mem_in, 0 = alu_in
//   regwrt                    register write enable
//   w_reg                     destination register index
//   alu_in, mem_in            candidate writeback values
//   rd_addr_a/b, rd_data_a/b  decode-stage read ports (combinational)
//   wb_data                   selected writeback value (combinational)
//   wb_fire                   registered pulse, commit happened on previous edge
//   retire_cnt                16-bit wrapping count of committed writes
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic              mux3,
  input  logic              regwrt,
  input  logic [ADDR_W-1:0] w_reg,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fire,
  output logic [15:0]       retire_cnt
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_IDX);

  logic              commit;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;

  assign wb_data = mux3 ? mem_in : alu_in;

  // A write to R0 is not a commit: no store, no count, no fire.
  assign commit = wb_valid & regwrt & (w_reg != R0);

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (w_reg),
    .wdata   (wb_data),
    .raddr_a (rd_addr_a),
    .rdata_a (core_a),
    .raddr_b (rd_addr_b),
    .rdata_b (core_b)
  );

  always_comb begin
    rd_data_a = core_a;
    rd_data_b = core_b;
`ifdef WB_BYPASS_EN
    // commit already excludes R0, so bypass can never target it.
    if (commit && (rd_addr_a == w_reg)) rd_data_a = wb_data;
    if (commit && (rd_addr_b == w_reg)) rd_data_b = wb_data;
`endif
    if (rd_addr_a == R0) rd_data_a = '0;
    if (rd_addr_b == R0) rd_data_b = '0;
  end

  // Reset outranks a commit in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_fire    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      wb_fire <= commit;
      if (commit) retire_cnt <= retire_cnt + 16'd1;
    end
  end

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile
//   Self-checking bench for wb_regfile (default DATA_W=8, ADDR_W=4).
//   Reference model: an array of register values, an integer commit count and
//   a fire flag, updated once per clock edge from the architectural rules.
//   Honors WB_BYPASS_EN in the expected read value.
module tb_wb_regfile;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int NREGS = 16;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic          mux3;
  logic          regwrt;
  logic [AW-1:0] w_reg;
  logic [DW-1:0] alu_in;
  logic [DW-1:0] mem_in;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rd_data_a;
  logic [DW-1:0] rd_data_b;
  logic [DW-1:0] wb_data;
  logic          wb_fire;
  logic [15:0]   retire_cnt;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .mux3       (mux3),
    .regwrt     (regwrt),
    .w_reg      (w_reg),
    .alu_in     (alu_in),
    .mem_in     (mem_in),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wb_data    (wb_data),
    .wb_fire    (wb_fire),
    .retire_cnt (retire_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_regs [NREGS];
  int unsigned m_cnt;
  bit          m_fire;
  bit          bypass_mode;

  int n_checks;
  int n_errors;

  function automatic int unsigned exp_wb_data();
    return mux3 ? int'(mem_in) : int'(alu_in);
  endfunction

  function automatic bit exp_commit();
    return wb_valid && regwrt && (int'(w_reg) != 0);
  endfunction

  function automatic int unsigned exp_read(input int addr);
    if (addr == 0) return 0;
    if (bypass_mode && exp_commit() && addr == int'(w_reg)) return exp_wb_data();
    return m_regs[addr];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit rw, input bit m3, input int wr,
                       input int alu, input int mem, input int ra, input int rb);
    wb_valid  = v;
    regwrt    = rw;
    mux3      = m3;
    w_reg     = AW'(wr);
    alu_in    = DW'(alu);
    mem_in    = DW'(mem);
    rd_addr_a = AW'(ra);
    rd_addr_b = AW'(rb);
    #1;
  endtask

  // One clock edge; the model advances from the inputs present at the edge.
  task automatic tick();
    bit c;
    int unsigned d;
    @(posedge clk);
    c = exp_commit();
    d = exp_wb_data();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
      m_cnt  = 0;
      m_fire = 0;
    end else begin
      if (c) begin
        m_regs[w_reg] = d;
        m_cnt = (m_cnt + 1) % 65536;
      end
      m_fire = c;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".wb_data"},    32'(wb_data),    exp_wb_data());
    check({tag, ".rd_a"},       32'(rd_data_a),  exp_read(int'(rd_addr_a)));
    check({tag, ".rd_b"},       32'(rd_data_b),  exp_read(int'(rd_addr_b)));
    check({tag, ".wb_fire"},    32'(wb_fire),    32'(m_fire));
    check({tag, ".retire_cnt"}, 32'(retire_cnt), m_cnt);
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, int'(rd_addr_a), int'(rd_addr_b));
  endtask

  task automatic check_all_regs_zero(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      drive(0, 0, 0, 0, 0, 0, i, NREGS - 1 - i);
      check({tag, ".rd_a"}, 32'(rd_data_a), 32'd0);
      check({tag, ".rd_b"}, 32'(rd_data_b), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned old_r7;
    int unsigned cnt_before;
    n_checks = 0;
    n_errors = 0;
`ifdef WB_BYPASS_EN
    bypass_mode = 1'b1;
`else
    bypass_mode = 1'b0;
`endif
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_cnt  = 0;
    m_fire = 0;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    // First commit on the first edge after reset deasserts.
    drive(1, 1, 0, 2, 8'h77, 8'h00, 2, 2);
    check_all("first_commit_pre");
    tick();
    bubble();
    check_all("first_commit_post");
    check("first_commit.r2", 32'(rd_data_a), 32'h77);
    check("first_commit.fire", 32'(wb_fire), 32'd1);

    // Source select on R3.
    drive(1, 1, 0, 3, 8'h5A, 8'hC3, 3, 3);
    check("sel.alu_wb_data", 32'(wb_data), 32'h5A);
    tick();
    bubble();
    check("sel.r3_alu", 32'(rd_data_a), 32'h5A);
    drive(1, 1, 1, 3, 8'h5A, 8'hC3, 3, 3);
    check("sel.mem_wb_data", 32'(wb_data), 32'hC3);
    tick();
    bubble();
    check("sel.r3_mem", 32'(rd_data_b), 32'hC3);
    check("sel.cnt", 32'(retire_cnt), 32'd3);

    // R0 guard.
    tick();
    cnt_before = m_cnt;
    drive(1, 1, 0, 0, 8'hFF, 8'hEE, 0, 0);
    check_all("r0_pre");
    tick();
    bubble();
    check("r0.rd_a", 32'(rd_data_a), 32'd0);
    check("r0.fire", 32'(wb_fire), 32'd0);
    check("r0.cnt", 32'(retire_cnt), cnt_before);

    // Bubble: regwrt without wb_valid.
    drive(0, 1, 0, 5, 8'h11, 8'h22, 5, 5);
    check_all("bubble_pre");
    tick();
    check("bubble.r5", 32'(rd_data_a), 32'd0);
    check("bubble.fire", 32'(wb_fire), 32'd0);
    check("bubble.cnt", 32'(retire_cnt), cnt_before);

    // Bypass / no-bypass on R7.
    drive(1, 1, 0, 7, 8'h10, 8'h00, 0, 0);
    tick();
    old_r7 = 32'h10;
    drive(1, 1, 0, 7, 8'h42, 8'h00, 7, 1);
    check("bypass.pre_edge", 32'(rd_data_a), bypass_mode ? 32'h42 : old_r7);
    check_all("bypass_pre");
    tick();
    bubble();
    check("bypass.post_edge", 32'(rd_data_a), 32'h42);

    // Back-to-back commits to the same register keep the later value.
    drive(1, 1, 0, 9, 8'hA1, 8'h00, 9, 9);
    tick();
    drive(1, 1, 1, 9, 8'h00, 8'hB2, 9, 9);
    tick();
    bubble();
    check("b2b.r9", 32'(rd_data_a), 32'hB2);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int wr;
      wr = $urandom_range(0, NREGS - 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, wr,
            $urandom_range(0, 255), $urandom_range(0, 255),
            ($urandom_range(0, 2) == 0) ? wr : $urandom_range(0, NREGS - 1),
            ($urandom_range(0, 2) == 0) ? wr : $urandom_range(0, NREGS - 1));
      check_all("rand");
      tick();
    end
    bubble();
    check_all("rand_end");

    // Reset with a commit pending: everything clears, commit suppressed.
    rst = 1'b1;
    drive(1, 1, 0, 6, 8'h99, 8'h00, 6, 6);
    tick();
    rst = 1'b0;
    bubble();
    check("reset.fire", 32'(wb_fire), 32'd0);
    check("reset.cnt", 32'(retire_cnt), 32'd0);
    check_all_regs_zero("reset");

    // Counter wrap: 65535 commits, then one more.
    for (int n = 0; n < 65535; n++) begin
      drive(1, 1, 0, 1 + (n % (NREGS - 1)), n & 255, 0, 1, 2);
      tick();
    end
    bubble();
    check("wrap.full", 32'(retire_cnt), 32'hFFFF);
    check_all("wrap_full");
    drive(1, 1, 1, 4, 8'h00, 8'h3C, 4, 4);
    tick();
    bubble();
    check("wrap.zero", 32'(retire_cnt), 32'h0000);
    check("wrap.fire", 32'(wb_fire), 32'd1);
    check("wrap.r4", 32'(rd_data_a), 32'h3C);
    tick();
    check("wrap.fire_drop", 32'(wb_fire), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wb_regfile
